div_seq: RTL and testbench

Iterative 64-bit integer divide sequencer for the EX stage. It executes RV64M DIV/DIVU/REM/REMU and the W variants over multiple cycles, using a 65-bit subtract-with-carry-in step. The single-cycle alu cannot perform these operations. It uses a valid/ready handshake on both sides so the pipeline controller stalls EX while a divide is in flight. It honours pipeline flush.

---
 rtl/div_seq_pkg.sv | 51 +++++
 rtl/div_step.sv | 26 ++
 rtl/div_seq.sv | 168 ++++++++++++++++
 tb/tb_div_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared definitions for the iterative divide sequencer: fu_op codes,
// FSM state encoding and small decode/extension helpers.
package div_seq_pkg;

    // fu_op codes of the divide family (shared EX-unit encoding)
    localparam logic [6:0] FU_DIV   = 7'h30;
    localparam logic [6:0] FU_DIVU  = 7'h31;
    localparam logic [6:0] FU_REM   = 7'h32;
    localparam logic [6:0] FU_REMU  = 7'h33;
    localparam logic [6:0] FU_DIVW  = 7'h34;
    localparam logic [6:0] FU_DIVUW = 7'h35;
    localparam logic [6:0] FU_REMW  = 7'h36;
    localparam logic [6:0] FU_REMUW = 7'h37;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_CALC  = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic valid;
        logic is_w;
        logic is_signed;
        logic is_rem;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [6:0] op);
        op_info_t info;
        info = '0;
        case (op)
            FU_DIV:   info = '{valid: 1'b1, is_w: 1'b0, is_signed: 1'b1, is_rem: 1'b0};
            FU_DIVU:  info = '{valid: 1'b1, is_w: 1'b0, is_signed: 1'b0, is_rem: 1'b0};
            FU_REM:   info = '{valid: 1'b1, is_w: 1'b0, is_signed: 1'b1, is_rem: 1'b1};
            FU_REMU:  info = '{valid: 1'b1, is_w: 1'b0, is_signed: 1'b0, is_rem: 1'b1};
            FU_DIVW:  info = '{valid: 1'b1, is_w: 1'b1, is_signed: 1'b1, is_rem: 1'b0};
            FU_DIVUW: info = '{valid: 1'b1, is_w: 1'b1, is_signed: 1'b0, is_rem: 1'b0};
            FU_REMW:  info = '{valid: 1'b1, is_w: 1'b1, is_signed: 1'b1, is_rem: 1'b1};
            FU_REMUW: info = '{valid: 1'b1, is_w: 1'b1, is_signed: 1'b0, is_rem: 1'b1};
            default:  info = '0;
        endcase
        return info;
    endfunction

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the partial remainder left, bring in
// the next dividend bit, and keep the trial difference if it is non-negative.
module div_step (
    input  logic [64:0] rem_i,
    input  logic [63:0] divisor_i,
    input  logic        dividend_msb_i,
    output logic [64:0] rem_o,
    output logic        q_bit_o
);

    logic [64:0] shifted;
    logic [65:0] sum;
    logic        fits;

    assign shifted = {rem_i[63:0], dividend_msb_i};

    // rem + ~div + 1 on 65 bits; the carry-out means shifted >= divisor.
    // A set rem_i[64] means the shifted value overflowed 65 bits, which is
    // always at least the divisor.
    assign sum  = {1'b0, shifted} + {1'b0, ~{1'b0, divisor_i}} + 66'd1;
    assign fits = sum[65] | rem_i[64];

    assign rem_o   = fits ? sum[64:0] : shifted;
    assign q_bit_o = fits;

endmodule

// File: rtl/div_seq.sv
// Iterative RV64M divide/remainder sequencer with valid/ready handshakes
// on both sides and pipeline flush support.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [6:0]  fu_op_i,
    input  logic [63:0] operand_a_i,
    input  logic [63:0] operand_b_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        flush_i,
    output logic [63:0] result_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        busy_o
);

    localparam logic [5:0] CNT_64 = 6'(64 / BITS_PER_CYCLE - 1);
    localparam logic [5:0] CNT_32 = 6'(32 / BITS_PER_CYCLE - 1);

    state_t      state, next_state;
    logic [6:0]  op_q;
    logic [63:0] a_q, b_q;
    logic [63:0] dividend_q;
    logic [64:0] rem_q;
    logic [63:0] divisor_q;
    logic        sign_q_q, sign_r_q;
    logic [5:0]  count_q;
    logic [63:0] result_q;
    logic        accept;
    op_info_t    info;

    assign info       = decode_op(op_q);
    assign in_ready_o = (state == ST_IDLE) & ~flush_i & ~rst_i;
    assign accept     = in_valid_i & in_ready_o;
    assign result_o   = result_q;

    // Operand preparation: width extension, signs, magnitudes, special cases
    logic [63:0] ext_a, ext_b, abs_a, abs_b, most_neg, special_result;
    logic        neg_a, neg_b, b_zero, overflow, special;

    assign ext_a = info.is_w ? (info.is_signed ? sext32(a_q[31:0]) : {32'b0, a_q[31:0]}) : a_q;
    assign ext_b = info.is_w ? (info.is_signed ? sext32(b_q[31:0]) : {32'b0, b_q[31:0]}) : b_q;
    assign neg_a = info.is_signed & ext_a[63];
    assign neg_b = info.is_signed & ext_b[63];
    assign abs_a = neg_a ? (64'd0 - ext_a) : ext_a;
    assign abs_b = neg_b ? (64'd0 - ext_b) : ext_b;

    assign most_neg = info.is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    assign b_zero   = (ext_b == 64'd0);
    assign overflow = info.is_signed & (ext_a == most_neg) & (ext_b == '1);
    assign special  = ~info.valid | b_zero | overflow;

    // Result for the cases that skip the iterative loop
    always_comb begin
        special_result = 64'd0;
        if (!info.valid) begin
            special_result = 64'd0;
        end else if (b_zero) begin
            if (info.is_rem) special_result = info.is_w ? sext32(a_q[31:0]) : a_q;
            else             special_result = '1;
        end else if (overflow) begin
            special_result = info.is_rem ? 64'd0 : ext_a;
        end
    end

    // Chain of restoring steps retiring BITS_PER_CYCLE quotient bits per cycle
    logic [64:0]               rem_chain [0:BITS_PER_CYCLE];
    logic [BITS_PER_CYCLE-1:0] q_bits;
    logic [63:0]               dividend_next;

    assign rem_chain[0] = rem_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        div_step u_step (
            .rem_i          (rem_chain[i]),
            .divisor_i      (divisor_q),
            .dividend_msb_i (dividend_q[63-i]),
            .rem_o          (rem_chain[i+1]),
            .q_bit_o        (q_bits[BITS_PER_CYCLE-1-i])
        );
    end

    assign dividend_next = {dividend_q[63-BITS_PER_CYCLE:0], q_bits};

    // Sign correction and quotient/remainder selection
    logic [63:0] q_fix, r_fix, sel, fix_result;

    assign q_fix      = sign_q_q ? (64'd0 - dividend_q) : dividend_q;
    assign r_fix      = sign_r_q ? (64'd0 - rem_q[63:0]) : rem_q[63:0];
    assign sel        = info.is_rem ? r_fix : q_fix;
    assign fix_result = info.is_w ? sext32(sel[31:0]) : sel;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next-state logic and status outputs; flush overrides every transition
    always_comb begin
        next_state  = state;
        out_valid_o = 1'b0;
        busy_o      = 1'b1;
        case (state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (accept) next_state = ST_PREP;
            end
            ST_PREP:  next_state = special ? ST_DONE : ST_CALC;
            ST_CALC:  if (count_q == 6'd0) next_state = ST_FIXUP;
            ST_FIXUP: next_state = ST_DONE;
            ST_DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) next_state = ST_IDLE;
            end
            default:  next_state = ST_IDLE;
        endcase
        if (flush_i) next_state = ST_IDLE;
    end

    // Datapath registers: capture on accept, set up in PREP, iterate in CALC
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            dividend_q <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            sign_q_q   <= 1'b0;
            sign_r_q   <= 1'b0;
            count_q    <= '0;
            result_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q <= fu_op_i;
                        a_q  <= operand_a_i;
                        b_q  <= operand_b_i;
                    end
                end
                ST_PREP: begin
                    sign_q_q   <= neg_a ^ neg_b;
                    sign_r_q   <= neg_a;
                    divisor_q  <= abs_b;
                    rem_q      <= '0;
                    dividend_q <= info.is_w ? {abs_a[31:0], 32'd0} : abs_a;
                    count_q    <= info.is_w ? CNT_32 : CNT_64;
                    if (special) result_q <= special_result;
                end
                ST_CALC: begin
                    rem_q      <= rem_chain[BITS_PER_CYCLE];
                    dividend_q <= dividend_next;
                    count_q    <= count_q - 6'd1;
                end
                ST_FIXUP: result_q <= fix_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed testbench for div_seq with hand-computed expected values.
module tb_div_seq;
    import div_seq_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [6:0]  fu_op_i = '0;
    logic [63:0] operand_a_i = '0;
    logic [63:0] operand_b_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic        flush_i = 1'b0;
    logic [63:0] result_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    div_seq #(.BITS_PER_CYCLE(1)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .fu_op_i     (fu_op_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .flush_i     (flush_i),
        .result_o    (result_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o)
    );

    // Free-running clock
    always #5 clk_i = ~clk_i;

    // Global time limit
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Issue one op; lat counts cycles after the accept edge (PREP is cycle 1),
    // -1 when no result appears within the bound. Operands are scrambled
    // right after the accept edge.
    task automatic run_op(input logic [6:0] op, input logic [63:0] a, input logic [63:0] b,
                          input bit take, output logic [63:0] res, output int lat);
        int guard;
        @(negedge clk_i);
        guard = 0;
        while (!in_ready_o && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        fu_op_i = op; operand_a_i = a; operand_b_i = b; in_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid_i  = 1'b0;
        operand_a_i = {$urandom, $urandom};
        operand_b_i = {$urandom, $urandom};
        fu_op_i     = 7'($urandom);
        lat = 0;
        do begin
            @(negedge clk_i);
            lat++;
        end while (!out_valid_o && lat < 200);
        res = result_o;
        if (!out_valid_o) lat = -1;
        if (take) begin
            out_ready_i = 1'b1;
            @(posedge clk_i);
            #1 out_ready_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        total++; if (in_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_in_ready: got=%b exp=0", in_ready_o); end
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid: got=%b exp=0", out_valid_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got=%b exp=0", busy_o); end
        total++; if (result_o !== 64'd0) begin bad++; $display("[TB] FAIL rst_result: got=%h exp=0", result_o); end
        rst_i = 1'b0;
        @(negedge clk_i);
        total++; if (in_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL post_rst_in_ready: got=%b exp=1", in_ready_o); end
    endtask

    task automatic test_unsigned();
        logic [63:0] r; int l;
        run_op(FU_DIVU, 64'd100, 64'd7, 1'b1, r, l);
        total++; if (r !== 64'd14) begin bad++; $display("[TB] FAIL divu_100_7: got=%h exp=%h", r, 64'd14); end
        total++; if (l != 67) begin bad++; $display("[TB] FAIL divu_latency: got=%0d exp=67", l); end
        run_op(FU_REMU, 64'd100, 64'd7, 1'b1, r, l);
        total++; if (r !== 64'd2 || l != 67) begin bad++; $display("[TB] FAIL remu_100_7: got=%h lat=%0d exp=%h lat=67", r, l, 64'd2); end
        run_op(FU_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 1'b1, r, l);
        total++; if (r !== 64'h0FFF_FFFF_FFFF_FFFF || l < 0) begin bad++; $display("[TB] FAIL divu_max_16: got=%h exp=0fffffffffffffff", r); end
        run_op(FU_REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 1'b1, r, l);
        total++; if (r !== 64'hF || l < 0) begin bad++; $display("[TB] FAIL remu_max_16: got=%h exp=f", r); end
    endtask

    task automatic test_signed();
        logic [63:0] r; int l;
        run_op(FU_DIV, -64'sd7, 64'd2, 1'b1, r, l);
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD || l < 0) begin bad++; $display("[TB] FAIL div_m7_2: got=%h exp=fffffffffffffffd", r); end
        run_op(FU_REM, -64'sd7, 64'd2, 1'b1, r, l);
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF || l < 0) begin bad++; $display("[TB] FAIL rem_m7_2: got=%h exp=ffffffffffffffff", r); end
        run_op(FU_REM, 64'd7, -64'sd2, 1'b1, r, l);
        total++; if (r !== 64'd1 || l < 0) begin bad++; $display("[TB] FAIL rem_7_m2: got=%h exp=1", r); end
        run_op(FU_DIVW, 64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, r, l);
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD || l != 35) begin bad++; $display("[TB] FAIL divw_m7_2: got=%h lat=%0d exp=fffffffffffffffd lat=35", r, l); end
        run_op(FU_REMW, 64'h1234_5678_FFFF_FFF9, 64'd2, 1'b1, r, l);
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF || l < 0) begin bad++; $display("[TB] FAIL remw_m7_2: got=%h exp=ffffffffffffffff", r); end
    endtask

    task automatic test_special();
        logic [63:0] r; int l;
        run_op(FU_DIV, 64'd5, 64'd0, 1'b1, r, l);
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF || l != 2) begin bad++; $display("[TB] FAIL div_by_zero: got=%h lat=%0d exp=ffffffffffffffff lat=2", r, l); end
        run_op(FU_REM, 64'd5, 64'd0, 1'b1, r, l);
        total++; if (r !== 64'd5 || l != 2) begin bad++; $display("[TB] FAIL rem_by_zero: got=%h lat=%0d exp=5 lat=2", r, l); end
        run_op(FU_REMW, 64'h0000_0001_8000_0000, 64'd0, 1'b1, r, l);
        total++; if (r !== 64'hFFFF_FFFF_8000_0000 || l != 2) begin bad++; $display("[TB] FAIL remw_by_zero: got=%h exp=ffffffff80000000", r); end
        run_op(7'h7F, 64'd100, 64'd7, 1'b1, r, l);
        total++; if (r !== 64'd0 || l != 2) begin bad++; $display("[TB] FAIL bad_opcode: got=%h lat=%0d exp=0 lat=2", r, l); end
    endtask

    task automatic test_overflow();
        logic [63:0] r; int l;
        run_op(FU_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, r, l);
        total++; if (r !== 64'h8000_0000_0000_0000 || l != 2) begin bad++; $display("[TB] FAIL div_overflow: got=%h lat=%0d exp=8000000000000000 lat=2", r, l); end
        run_op(FU_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, r, l);
        total++; if (r !== 64'd0 || l != 2) begin bad++; $display("[TB] FAIL rem_overflow: got=%h lat=%0d exp=0 lat=2", r, l); end
        run_op(FU_DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, r, l);
        total++; if (r !== 64'hFFFF_FFFF_8000_0000 || l != 2) begin bad++; $display("[TB] FAIL divw_overflow: got=%h lat=%0d exp=ffffffff80000000 lat=2", r, l); end
    endtask

    task automatic test_hold();
        logic [63:0] r; int l;
        run_op(FU_DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, r, l);
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF || l != 35) begin bad++; $display("[TB] FAIL divuw_max_1: got=%h lat=%0d exp=ffffffffffffffff lat=35", r, l); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            total++;
            if (out_valid_o !== 1'b1 || result_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
                bad++; $display("[TB] FAIL hold_stable: got valid=%b res=%h exp valid=1 res=ffffffffffffffff", out_valid_o, result_o);
            end
        end
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1 out_ready_i = 1'b0;
        @(negedge clk_i);
        total++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL after_handshake: got ready=%b valid=%b exp ready=1 valid=0", in_ready_o, out_valid_o); end
    endtask

    task automatic test_flush();
        logic [63:0] r; int l; int seen;
        @(negedge clk_i);
        fu_op_i = FU_DIVU; operand_a_i = 64'd100; operand_b_i = 64'd7; in_valid_i = 1'b1;
        @(posedge clk_i);
        #1 in_valid_i = 1'b0;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1 flush_i = 1'b0;
        @(negedge clk_i);
        total++; if (in_ready_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("[TB] FAIL flush_calc_idle: got ready=%b busy=%b exp ready=1 busy=0", in_ready_o, busy_o); end
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk_i);
            if (out_valid_o) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("[TB] FAIL flush_no_result: got valid_cycles=%0d exp=0", seen); end
        run_op(FU_DIVU, 64'd9, 64'd3, 1'b1, r, l);
        total++; if (r !== 64'd3 || l != 67) begin bad++; $display("[TB] FAIL divu_9_3: got=%h lat=%0d exp=3 lat=67", r, l); end

        // Flush together with a request: nothing may be accepted
        @(negedge clk_i);
        fu_op_i = FU_DIV; operand_a_i = 64'd5; operand_b_i = 64'd0;
        in_valid_i = 1'b1; flush_i = 1'b1;
        #1;
        total++; if (in_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL flush_blocks_ready: got=%b exp=0", in_ready_o); end
        @(posedge clk_i);
        #1 begin in_valid_i = 1'b0; flush_i = 1'b0; end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (busy_o || out_valid_o) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("[TB] FAIL flush_no_accept: got active_cycles=%0d exp=0", seen); end

        // Flush while a result waits in DONE, with out_ready also high
        run_op(FU_DIV, 64'd5, 64'd0, 1'b0, r, l);
        flush_i = 1'b1; out_ready_i = 1'b1;
        @(posedge clk_i);
        #1 begin flush_i = 1'b0; out_ready_i = 1'b0; end
        @(negedge clk_i);
        total++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("[TB] FAIL flush_done: got valid=%b busy=%b exp 0 0", out_valid_o, busy_o); end
    endtask

    task automatic test_reset_abort();
        int seen;
        @(negedge clk_i);
        fu_op_i = FU_DIVU; operand_a_i = 64'd1000; operand_b_i = 64'd3; in_valid_i = 1'b1;
        @(posedge clk_i);
        #1 in_valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk_i);
            if (out_valid_o || busy_o) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("[TB] FAIL reset_abort: got active_cycles=%0d exp=0", seen); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_overflow();
        test_hold();
        test_flush();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
